shift_unit_seq: RTL
===================

Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle, multi-mode shifter for the ALU shift path.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right.
- Works iteratively: each cycle applies one power-of-two stage of the shift amount.
- Uses valid/ready handshakes on both input and output, so a shift can stall the execute stage rather than sit in the combinational critical path.

Parameters:
- WIDTH, 32: data width. Must be a power of two and at least 2.
- AMT_W, 32: width of the shift-amount operand (a full register value).
- LG, $clog2(WIDTH): number of shift stages, which is also the latency in cycles. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept an operand bundle.
- in_data  in  WIDTH  value to shift.
- in_amt  in  AMT_W  shift amount, unsigned.
- in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_illegal  out  1  the accepted in_mode was illegal.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=1, out_illegal=0.
  - The stage counter and captured mode/amount are cleared.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0; stage counter k runs 0..LG-1.
  - HOLD: in_ready=0, out_valid=1.
- Accept (IDLE): in_valid=1 on a rising edge captures in_data, in_amt[LG-1:0] and in_mode.
  - Also captures over = |in_amt[AMT_W-1:LG] (0 when AMT_W <= LG).
  - k is set to 0 and the state moves to RUN.
- RUN, each cycle: if amt[k]=1, shift the working register by 2^k per mode.
  - SLL: zero-fill low bits.
  - SRL: zero-fill high bits.
  - SRA: fill high bits with the original bit WIDTH-1.
  - ROL/ROR: wrap the shifted-out bits around.
  - After stage k=LG-1 the state moves to HOLD.
- Latency: fixed at LG cycles, independent of amount and mode.
  - For a handshake on edge N, out_valid is first high after edge N+LG (edge N+5 for WIDTH=32).
- Over-range amount (over=1):
  - SLL and SRL: result is all zeros.
  - SRA: result is all copies of the sign bit.
  - ROL and ROR: over is ignored; the effective amount is in_amt mod WIDTH.
  - Latency is still LG cycles.
- Amount 0: result equals in_data for every mode.
- Illegal mode:
  - result = in_data unchanged and out_illegal=1.
  - out_illegal holds for the whole HOLD period and clears on the transfer.
- HOLD:
  - out_data, out_zero and out_illegal are stable while out_valid=1 and out_ready=0.
  - out_valid=1 with out_ready=1 on an edge completes the transfer; the state returns to IDLE and out_valid drops.
  - No same-cycle re-accept: the next bundle is taken no earlier than the following edge.
- Inputs during RUN/HOLD: in_valid is ignored and nothing is captured (in_ready=0).
- out_zero is registered together with out_data when entering HOLD.
- Reset mid-operation (RUN or HOLD): the in-flight result is discarded.
  - Outputs immediately take their reset values; no output transfer occurs.

Test Plan:
- WIDTH=32, SRL, in_data=0x8000_0001, in_amt=4 -> out_data=0x0800_0000; out_valid exactly 5 cycles after accept.
- SRA, in_data=0x8000_0000, in_amt=31 -> 0xFFFF_FFFF.
- SRA, in_data=0x8000_0000, in_amt=0x20 (over) -> 0xFFFF_FFFF.
- SLL, in_data=0x1, in_amt=0x100 -> 0x0000_0000 and out_zero=1.
- ROL, in_data=0x8000_0001, in_amt=33 -> 0x0000_0003.
- ROR, in_data=0x0000_0001, in_amt=1 -> 0x8000_0000.
- Hold out_ready=0 for 3 cycles in HOLD -> out_data stable and in_ready=0; a new in_valid pulse during RUN is ignored.
- in_mode=3'b111, in_data=0x1234_5678 -> out_data=0x1234_5678 and out_illegal=1.
- Assert rst at RUN stage 2 -> out_valid=0, in_ready=1 at once; a fresh SLL 0x1 by 1 afterwards returns 0x2.

Source files
------------

// File: rtl/shift_unit_seq_if.sv
// Operand/result handshake bundle for the iterative shifter.
// master drives operands and consumes results; slave is the shifter itself.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_illegal;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_illegal
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: one power-of-two stage per cycle, fixed LG-cycle latency,
// valid/ready on both sides so a long shift stalls execute instead of timing.
//
//   state  | meaning
//   IDLE   | ready for an operand bundle
//   RUN    | applying stage k_q (0..LG-1) of the captured amount
//   HOLD   | result presented, waiting for out_ready
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32,
    parameter int LG    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    shift_unit_seq_if.slave  bus_io
);
    localparam logic [2:0]    M_SLL  = 3'b000;
    localparam logic [2:0]    M_SRL  = 3'b001;
    localparam logic [2:0]    M_SRA  = 3'b010;
    localparam logic [2:0]    M_ROL  = 3'b011;
    localparam logic [2:0]    M_ROR  = 3'b100;
    localparam logic [LG-1:0] K_LAST = LG'(LG - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t           state_q;
    logic [LG-1:0]    k_q;
    logic [LG-1:0]    amt_q;
    logic [2:0]       mode_q;
    logic             over_q;
    logic             sign_q;
    logic [WIDTH-1:0] work_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_zero_q;
    logic             out_illegal_q;

    logic             over_in;
    logic [LG:0]      step;
    logic [LG-1:0]    amt_sh;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] final_d;
    logic             illegal;

    generate
        if (AMT_W > LG) begin : g_over
            assign over_in = |bus_io.in_amt[AMT_W-1:LG];
        end else begin : g_no_over
            assign over_in = 1'b0;
        end
    endgenerate

    assign illegal = (mode_q > M_ROR);

    always_comb begin
        step    = (LG + 1)'(1) << k_q;
        amt_sh  = amt_q >> k_q;
        shifted = work_q;
        case (mode_q)
            M_SLL:   shifted = work_q << step;
            M_SRL:   shifted = work_q >> step;
            // Fill uses the sign captured at accept, not the partially shifted word.
            M_SRA:   shifted = (work_q >> step) | ({WIDTH{sign_q}} << (WIDTH - step));
            M_ROL:   shifted = (work_q << step) | (work_q >> (WIDTH - step));
            M_ROR:   shifted = (work_q >> step) | (work_q << (WIDTH - step));
            default: shifted = work_q;
        endcase
        work_d  = amt_sh[0] ? shifted : work_q;
        final_d = work_d;
        // Rotates wrap naturally, so only the plain shifts saturate on over-range.
        if (over_q) begin
            case (mode_q)
                M_SLL, M_SRL: final_d = '0;
                M_SRA:        final_d = {WIDTH{sign_q}};
                default:      final_d = work_d;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            amt_q         <= '0;
            mode_q        <= '0;
            over_q        <= 1'b0;
            sign_q        <= 1'b0;
            work_q        <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_zero_q    <= 1'b1;
            out_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_io.in_valid) begin
                        work_q     <= bus_io.in_data;
                        sign_q     <= bus_io.in_data[WIDTH-1];
                        amt_q      <= bus_io.in_amt[LG-1:0];
                        mode_q     <= bus_io.in_mode;
                        over_q     <= over_in;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    k_q    <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        k_q           <= '0;
                        out_valid_q   <= 1'b1;
                        out_data_q    <= final_d;
                        out_zero_q    <= (final_d == '0);
                        out_illegal_q <= illegal;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus_io.out_ready) begin
                        out_valid_q   <= 1'b0;
                        out_illegal_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_io.in_ready    = in_ready_q;
    assign bus_io.out_valid   = out_valid_q;
    assign bus_io.out_data    = out_data_q;
    assign bus_io.out_zero    = out_zero_q;
    assign bus_io.out_illegal = out_illegal_q;
endmodule
